shift_operand_stage: RTL and testbench

Operand-2 stage of the data-processing path: accepts a decoded operand-2 descriptor, resolves the shift amount and drives the team's `barrelshifter` instance. Handles all three operand forms:
- rotated 8-bit immediate;
- immediate-shifted register;
- register-shifted register, fetching Rs over a request/response port.

It applies the ARM special cases the shifter alone cannot express (amount ≥32, #0 encodings, RRX), produces the shifter carry-out, and hands {operand, carry} to the ALU over a valid/ready handshake.

---
 rtl/shift_operand_stage.sv | 250 +++++++++++++++++++++++++
 tb/tb_shift_operand_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_operand_stage.sv
// Operand-2 stage: resolves immediate / immediate-shifted / register-shifted
// operands through a barrel shifter and hands {operand, carry} to the ALU.

module barrelshifter (
  input  logic [31:0] data,
  input  logic [2:0]  mode,
  input  logic [4:0]  count,
  output logic [31:0] result
);
  // mode: 000 LSL, 001 LSR, 011 ASR, 101 ROR
  always_comb begin
    result = data;
    case (mode)
      3'b000:  result = data << count;
      3'b001:  result = data >> count;
      3'b011:  result = $unsigned($signed(data) >>> count);
      3'b101:  result = (data >> count) | (data << (6'd32 - {1'b0, count}));
      default: result = data;
    endcase
  end
endmodule

// state   | meaning
// IDLE    | empty, ready for a descriptor
// RS_REQ  | issuing the one-cycle Rs read request
// RS_WAIT | waiting for Rs data to return
// OUT     | result presented to the ALU, held until out_ready
module shift_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        imm_form,
  input  logic [7:0]  imm8,
  input  logic [3:0]  rot4,
  input  logic [31:0] rm_value,
  input  logic [1:0]  shift_type,
  input  logic [4:0]  shift_imm,
  input  logic        reg_shift,
  input  logic [3:0]  rs_addr_in,
  input  logic        carry_in,
  output logic        rs_req,
  output logic [3:0]  rs_addr,
  input  logic        rs_valid,
  input  logic [31:0] rs_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_carry
);
  typedef enum logic [1:0] {IDLE, RS_REQ, RS_WAIT, OUT} state_t;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;

  state_t      state, state_next;
  logic        accept;
  logic        is_rsr_in;

  logic [31:0] rm_q;
  logic [1:0]  type_q;
  logic        cin_q;
  logic [3:0]  rs_addr_q;

  logic        use_q;
  logic        sel_imm;
  logic [31:0] sel_rm;
  logic [1:0]  sel_type;
  logic        sel_cin;
  logic [7:0]  sel_amt;

  logic [31:0] sh_data;
  logic [2:0]  sh_mode;
  logic [4:0]  sh_count;
  logic [31:0] sh_res;

  logic        amt_zero;
  logic        amt_ge32;
  logic        amt_is32;
  logic [4:0]  lsl_idx;
  logic [4:0]  rsh_idx;
  logic [31:0] res_data;
  logic        res_carry;
  logic        load_result;
  logic        unused_rs_hi;

  assign unused_rs_hi = ^rs_data[31:8];
  assign is_rsr_in    = !imm_form && reg_shift;
  assign accept       = in_valid && in_ready;

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) state_next = is_rsr_in ? RS_REQ : OUT;
      end
      RS_REQ:  state_next = RS_WAIT;
      RS_WAIT: begin
        if (rs_valid) state_next = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (in_valid) state_next = is_rsr_in ? RS_REQ : OUT;
          else          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = 1'b0;
    rs_req    = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready = 1'b1;
      RS_REQ:  rs_req = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: ;
    endcase
  end

  assign rs_addr = rs_addr_q;

  // Live descriptor feeds the shifter at accept; latched one while Rs is awaited.
  assign use_q    = (state == RS_WAIT);
  assign sel_imm  = !use_q && imm_form;
  assign sel_rm   = use_q ? rm_q   : rm_value;
  assign sel_type = use_q ? type_q : shift_type;
  assign sel_cin  = use_q ? cin_q  : carry_in;
  assign sel_amt  = use_q ? rs_data[7:0] : {3'b000, shift_imm};

  always_comb begin
    sh_data  = sel_rm;
    sh_count = sel_amt[4:0];
    sh_mode  = 3'b000;
    if (sel_imm) begin
      sh_data  = {24'd0, imm8};
      sh_mode  = 3'b101;
      sh_count = {rot4, 1'b0};
    end else begin
      case (sel_type)
        SH_LSL:  sh_mode = 3'b000;
        SH_LSR:  sh_mode = 3'b001;
        SH_ASR:  sh_mode = 3'b011;
        default: sh_mode = 3'b101;
      endcase
    end
  end

  barrelshifter u_shifter (
    .data   (sh_data),
    .mode   (sh_mode),
    .count  (sh_count),
    .result (sh_res)
  );

  assign amt_zero = (sel_amt == 8'd0);
  assign amt_ge32 = (sel_amt[7:5] != 3'b000);
  assign amt_is32 = (sel_amt == 8'd32);
  // Last bit shifted out for amounts 1..31: Rm[32-n] for LSL, Rm[n-1] otherwise.
  assign lsl_idx  = 5'd0 - sel_amt[4:0];
  assign rsh_idx  = sel_amt[4:0] - 5'd1;

  always_comb begin
    res_data  = sh_res;
    res_carry = sel_cin;
    if (sel_imm) begin
      res_data  = sh_res;
      res_carry = (rot4 == 4'd0) ? sel_cin : sh_res[31];
    end else if (!use_q) begin
      case (sel_type)
        SH_LSL: begin
          res_data  = amt_zero ? sel_rm  : sh_res;
          res_carry = amt_zero ? sel_cin : sel_rm[lsl_idx];
        end
        SH_LSR: begin
          res_data  = amt_zero ? 32'd0      : sh_res;
          res_carry = amt_zero ? sel_rm[31] : sel_rm[rsh_idx];
        end
        SH_ASR: begin
          res_data  = amt_zero ? {32{sel_rm[31]}} : sh_res;
          res_carry = amt_zero ? sel_rm[31]       : sel_rm[rsh_idx];
        end
        default: begin
          res_data  = amt_zero ? {sel_cin, sel_rm[31:1]} : sh_res;
          res_carry = amt_zero ? sel_rm[0]               : sel_rm[rsh_idx];
        end
      endcase
    end else if (amt_zero) begin
      res_data  = sel_rm;
      res_carry = sel_cin;
    end else begin
      case (sel_type)
        SH_LSL: begin
          res_data  = amt_ge32 ? 32'd0 : sh_res;
          res_carry = amt_ge32 ? (amt_is32 & sel_rm[0]) : sel_rm[lsl_idx];
        end
        SH_LSR: begin
          res_data  = amt_ge32 ? 32'd0 : sh_res;
          res_carry = amt_ge32 ? (amt_is32 & sel_rm[31]) : sel_rm[rsh_idx];
        end
        SH_ASR: begin
          res_data  = amt_ge32 ? {32{sel_rm[31]}} : sh_res;
          res_carry = amt_ge32 ? sel_rm[31]       : sel_rm[rsh_idx];
        end
        default: begin
          res_data  = (sel_amt[4:0] == 5'd0) ? sel_rm     : sh_res;
          res_carry = (sel_amt[4:0] == 5'd0) ? sel_rm[31] : sh_res[31];
        end
      endcase
    end
  end

  assign load_result = (accept && !is_rsr_in) || (use_q && rs_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rm_q      <= 32'd0;
      type_q    <= 2'd0;
      cin_q     <= 1'b0;
      rs_addr_q <= 4'd0;
      out_data  <= 32'd0;
      out_carry <= 1'b0;
    end else begin
      if (accept) begin
        rm_q      <= rm_value;
        type_q    <= shift_type;
        cin_q     <= carry_in;
        rs_addr_q <= rs_addr_in;
      end
      if (load_result) begin
        out_data  <= res_data;
        out_carry <= res_carry;
      end
    end
  end
endmodule

// File: tb/tb_shift_operand_stage.sv
// Randomized and directed checks of shift_operand_stage against a bit-serial
// model of the ARM operand-2 shift rules.

module tb_shift_operand_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        imm_form = 1'b0;
  logic [7:0]  imm8 = 8'd0;
  logic [3:0]  rot4 = 4'd0;
  logic [31:0] rm_value = 32'd0;
  logic [1:0]  shift_type = 2'd0;
  logic [4:0]  shift_imm = 5'd0;
  logic        reg_shift = 1'b0;
  logic [3:0]  rs_addr_in = 4'd0;
  logic        carry_in = 1'b0;
  logic        rs_req;
  logic [3:0]  rs_addr;
  logic        rs_valid = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_carry;

  int errors = 0;
  int checks = 0;

  shift_operand_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .imm_form   (imm_form),
    .imm8       (imm8),
    .rot4       (rot4),
    .rm_value   (rm_value),
    .shift_type (shift_type),
    .shift_imm  (shift_imm),
    .reg_shift  (reg_shift),
    .rs_addr_in (rs_addr_in),
    .carry_in   (carry_in),
    .rs_req     (rs_req),
    .rs_addr    (rs_addr),
    .rs_valid   (rs_valid),
    .rs_data    (rs_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_carry  (out_carry)
  );

  always #5 clk = ~clk;

  // Shift one bit at a time; carry is whatever bit fell off last.
  function automatic logic [32:0] ref_model(input logic immf, input logic [7:0] i8,
      input logic [3:0] r4, input logic [31:0] rm, input logic [1:0] st,
      input logic [4:0] si, input logic regs, input logic [7:0] n8, input logic cin);
    logic [31:0] v;
    logic        c;
    int          n;
    if (immf) begin
      v = {24'd0, i8};
      for (int i = 0; i < 2 * int'(r4); i++) v = {v[0], v[31:1]};
      c = (r4 == 4'd0) ? cin : v[31];
      return {c, v};
    end
    v = rm;
    c = cin;
    if (regs) n = int'(n8);
    else begin
      n = int'(si);
      if (n == 0) begin
        if (st == 2'b01 || st == 2'b10) n = 32;
        else if (st == 2'b11) return {rm[0], cin, rm[31:1]};
      end
    end
    for (int i = 0; i < n; i++) begin
      case (st)
        2'b00:   begin c = v[31]; v = {v[30:0], 1'b0}; end
        2'b01:   begin c = v[0];  v = {1'b0, v[31:1]}; end
        2'b10:   begin c = v[0];  v = {v[31], v[31:1]}; end
        default: begin c = v[0];  v = {v[0], v[31:1]}; end
      endcase
    end
    return {c, v};
  endfunction

  task automatic scramble_bus();
    imm_form   = 1'($urandom);
    imm8       = 8'($urandom);
    rot4       = 4'($urandom);
    rm_value   = $urandom;
    shift_type = 2'($urandom);
    shift_imm  = 5'($urandom);
    reg_shift  = 1'($urandom);
    rs_addr_in = 4'($urandom);
    carry_in   = 1'($urandom);
  endtask

  task automatic set_desc(input logic immf, input logic [7:0] i8, input logic [3:0] r4,
      input logic [31:0] rm, input logic [1:0] st, input logic [4:0] si,
      input logic regs, input logic [3:0] ra, input logic cin);
    imm_form = immf; imm8 = i8; rot4 = r4; rm_value = rm; shift_type = st;
    shift_imm = si; reg_shift = regs; rs_addr_in = ra; carry_in = cin;
  endtask

  // Issues one descriptor from IDLE with out_ready=1; Rs returns k cycles after rs_req.
  task automatic run_op(input string name, input logic immf, input logic [7:0] i8,
      input logic [3:0] r4, input logic [31:0] rm, input logic [1:0] st,
      input logic [4:0] si, input logic regs, input logic [3:0] ra,
      input logic [31:0] rsd, input logic cin, input int k,
      input logic [31:0] exp_d, input logic exp_c);
    set_desc(immf, i8, r4, rm, st, si, regs, ra, cin);
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL %s accept: in_ready=%b expected 1", name, in_ready);
    if (in_ready !== 1'b1) errors++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_bus();
    if (!immf && regs) begin
      checks++;
      if (rs_req !== 1'b1 || rs_addr !== ra || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s rs_req: rs_req=%b rs_addr=%h out_valid=%b expected 1 %h 0",
                 name, rs_req, rs_addr, out_valid, ra);
      end
      in_valid = 1'b1;
      for (int i = 0; i < k; i++) begin
        @(posedge clk); #1;
        checks++;
        if (rs_req !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL %s wait: rs_req=%b out_valid=%b in_ready=%b expected 0 0 0",
                   name, rs_req, out_valid, in_ready);
        end
        scramble_bus();
      end
      in_valid = 1'b0;
      rs_valid = 1'b1;
      rs_data  = rsd;
      @(posedge clk); #1;
      rs_valid = 1'b0;
      rs_data  = $urandom;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_d || out_carry !== exp_c) begin
      errors++;
      $display("FAIL %s result: valid=%b data=%h carry=%b expected 1 %h %b",
               name, out_valid, out_data, out_carry, exp_d, exp_c);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s drain: out_valid=%b in_ready=%b expected 0 1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_carry !== 1'b0 ||
        rs_req !== 1'b0 || rs_addr !== 4'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%b data=%h carry=%b rs_req=%b rs_addr=%h in_ready=%b expected 0 0 0 0 0 1",
               out_valid, out_data, out_carry, rs_req, rs_addr, in_ready);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_immediate();
    run_op("imm_ff_rot4", 1, 8'hFF, 4'd4, 32'h0, 2'd0, 5'd0, 0, 4'd0, 32'h0, 1'b0, 0,
           32'hFF00_0000, 1'b1);
    run_op("imm_rot0_cin", 1, 8'h80, 4'd0, 32'h0, 2'd0, 5'd0, 0, 4'd0, 32'h0, 1'b1, 0,
           32'h0000_0080, 1'b1);
  endtask

  task automatic test_imm_shift_specials();
    run_op("lsr0", 0, 8'd0, 4'd0, 32'h8000_0001, 2'b01, 5'd0, 0, 4'd0, 32'h0, 1'b0, 0,
           32'h0000_0000, 1'b1);
    run_op("asr0", 0, 8'd0, 4'd0, 32'h8000_0001, 2'b10, 5'd0, 0, 4'd0, 32'h0, 1'b0, 0,
           32'hFFFF_FFFF, 1'b1);
    run_op("rrx", 0, 8'd0, 4'd0, 32'h8000_0001, 2'b11, 5'd0, 0, 4'd0, 32'h0, 1'b0, 0,
           32'h4000_0000, 1'b1);
    run_op("lsl0", 0, 8'd0, 4'd0, 32'h8000_0001, 2'b00, 5'd0, 0, 4'd0, 32'h0, 1'b1, 0,
           32'h8000_0001, 1'b1);
    run_op("lsl1", 0, 8'd0, 4'd0, 32'h8000_0001, 2'b00, 5'd1, 0, 4'd0, 32'h0, 1'b0, 0,
           32'h0000_0002, 1'b1);
  endtask

  task automatic test_reg_shift();
    run_op("rs_lsl32", 0, 8'd0, 4'd0, 32'h1, 2'b00, 5'd7, 1, 4'd5, 32'd32, 1'b0, 3,
           32'h0, 1'b1);
    run_op("rs_lsl33", 0, 8'd0, 4'd0, 32'h1, 2'b00, 5'd7, 1, 4'd9, 32'd33, 1'b1, 3,
           32'h0, 1'b0);
    run_op("rs_ror64", 0, 8'd0, 4'd0, 32'h1, 2'b11, 5'd7, 1, 4'd3, 32'h40, 1'b1, 3,
           32'h1, 1'b0);
    run_op("rs_n0_hi", 0, 8'd0, 4'd0, 32'h1234_5678, 2'b01, 5'd7, 1, 4'd15, 32'hFFFF_FF00,
           1'b1, 1, 32'h1234_5678, 1'b1);
  endtask

  task automatic test_random();
    logic        immf, regs, cin;
    logic [7:0]  i8, n8;
    logic [3:0]  r4, ra;
    logic [31:0] rm, rsd;
    logic [1:0]  st;
    logic [4:0]  si;
    logic [32:0] e;
    int          k;
    for (int t = 0; t < 80; t++) begin
      immf = ($urandom_range(0, 3) == 0);
      regs = 1'($urandom);
      cin  = 1'($urandom);
      i8   = 8'($urandom);
      r4   = 4'($urandom);
      rm   = $urandom;
      st   = 2'($urandom);
      si   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      ra   = 4'($urandom);
      n8   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
      rsd  = {$urandom} & 32'hFFFF_FF00 | {24'd0, n8};
      k    = $urandom_range(1, 4);
      e    = ref_model(immf, i8, r4, rm, st, si, regs, n8, cin);
      run_op("random", immf, i8, r4, rm, st, si, regs, ra, rsd, cin, k, e[31:0], e[32]);
    end
  endtask

  task automatic test_back_to_back();
    logic [32:0] e1, e2;
    logic        immf;
    logic [31:0] rm;
    logic [7:0]  i8;
    logic [3:0]  r4;
    logic [1:0]  st;
    logic [4:0]  si;
    logic        cin;
    out_ready = 1'b0;
    set_desc(0, 8'd0, 4'd0, 32'hC0DE_0F0F, 2'b10, 5'd4, 0, 4'd0, 1'b0);
    e1 = ref_model(0, 8'd0, 4'd0, 32'hC0DE_0F0F, 2'b10, 5'd4, 0, 8'd0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_bus();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== e1[31:0] || out_carry !== e1[32] || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure: valid=%b data=%h carry=%b in_ready=%b expected 1 %h %b 0",
                 out_valid, out_data, out_carry, in_ready, e1[31:0], e1[32]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    set_desc(1, 8'h3C, 4'd1, 32'h0, 2'd0, 5'd0, 0, 4'd0, 1'b0);
    e2 = ref_model(1, 8'h3C, 4'd1, 32'h0, 2'd0, 5'd0, 0, 8'd0, 1'b0);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL handover_ready: in_ready=%b expected 1", in_ready);
    end
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== e2[31:0] || out_carry !== e2[32]) begin
        errors++;
        $display("FAIL back_to_back: valid=%b data=%h carry=%b expected 1 %h %b",
                 out_valid, out_data, out_carry, e2[31:0], e2[32]);
      end
      immf = 1'($urandom);
      i8 = 8'($urandom); r4 = 4'($urandom); rm = $urandom;
      st = 2'($urandom); si = 5'($urandom); cin = 1'($urandom);
      set_desc(immf, i8, r4, rm, st, si, 0, 4'd0, cin);
      e2 = ref_model(immf, i8, r4, rm, st, si, 0, 8'd0, cin);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b expected 0", out_valid);
    end
  endtask

  task automatic test_reset_midop();
    set_desc(0, 8'd0, 4'd0, 32'hFFFF_0000, 2'b01, 5'd0, 1, 4'd6, 1'b0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rs_req !== 1'b0 || rs_addr !== 4'd0) begin
      errors++;
      $display("FAIL reset_wait: out_valid=%b rs_req=%b rs_addr=%h expected 0 0 0",
               out_valid, rs_req, rs_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    rs_valid = 1'b1;
    rs_data  = 32'd4;
    @(posedge clk); #1;
    rs_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || rs_req !== 1'b0) begin
        errors++;
        $display("FAIL late_rs_valid: out_valid=%b in_ready=%b rs_req=%b expected 0 1 0",
                 out_valid, in_ready, rs_req);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    set_desc(1, 8'hA5, 4'd2, 32'h0, 2'd0, 5'd0, 0, 4'd0, 1'b1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'd0 || out_carry !== 1'b0) begin
      errors++;
      $display("FAIL reset_out: valid=%b data=%h carry=%b expected 0 0 0",
               out_valid, out_data, out_carry);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_out_release: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_imm_shift_specials();
    test_reg_shift();
    test_random();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
